// File: rtl/spi_frame_driver.sv
// spi_frame_driver
//   Upstream stage of the FM25Q08A serial clock generator. Takes one command
//   descriptor at a time and drives a complete SPI mode-0 frame:
//   opcode, optional 24-bit address, dummy bits, write bytes, read bytes.
//   The serial clock C is derived from CLK, so every frame is cycle-exact.
//
// Parameters
//   DIV   : system cycles per serial-clock half period (>= 1)
//   CSS   : system cycles from S_n fall to the first C activity (>= 1)
//   CSH   : system cycles from the last C fall to S_n rise (>= 1)
//   DESEL : minimum system cycles S_n stays high before the next frame (>= 1)
//
// Ports
//   CLK, RST_N         : system clock (rising edge), async active-low reset
//   cmd_valid/ready    : descriptor handshake, ready only while idle
//   cmd_op/addr/...    : descriptor fields, latched on acceptance
//   wr_req, wr_data    : write byte request pulse, wr_data sampled same cycle
//   rd_valid, rd_data  : captured read byte with one-cycle valid pulse
//   busy               : frame in progress
//   clock_active       : high while bit cells are being generated
//   S_n, C, D, Q       : chip select, serial clock, MOSI, MISO
module spi_frame_driver #(
    parameter int DIV   = 2,
    parameter int CSS   = 2,
    parameter int CSH   = 2,
    parameter int DESEL = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic        cmd_addr_en,
    input  logic [3:0]  cmd_dummy,
    input  logic [7:0]  cmd_wr_len,
    input  logic [15:0] cmd_rd_len,
    output logic        wr_req,
    input  logic [7:0]  wr_data,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        clock_active,
    output logic        S_n,
    output logic        C,
    output logic        D,
    input  logic        Q
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_SETUP = 4'd1;
    localparam logic [3:0] ST_OP    = 4'd2;
    localparam logic [3:0] ST_ADDR  = 4'd3;
    localparam logic [3:0] ST_DUMMY = 4'd4;
    localparam logic [3:0] ST_WRITE = 4'd5;
    localparam logic [3:0] ST_READ  = 4'd6;
    localparam logic [3:0] ST_HOLD  = 4'd7;
    localparam logic [3:0] ST_DESEL = 4'd8;

    localparam logic [15:0] CELL_LAST  = 16'(2 * DIV - 1);
    localparam logic [15:0] C_RISE     = 16'(DIV);
    localparam logic [15:0] SETUP_LAST = 16'(CSS - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CSH - 1);
    localparam logic [15:0] DESEL_LAST = 16'(DESEL - 1);

    logic [3:0]  state;
    logic [15:0] cnt;        // cycle counter: within a bit cell, or wait length
    logic [4:0]  bit_cnt;    // bits left in the current field/byte, minus one
    logic [15:0] byte_cnt;   // bytes left in WRITE/READ, including current
    logic [23:0] shift;      // outgoing bits, MSB is the bit on D
    logic [7:0]  rx;
    logic        addr_en_q;
    logic [23:0] addr_q;
    logic [3:0]  dummy_q;
    logic [7:0]  wr_len_q;
    logic [15:0] rd_len_q;

    logic       in_bits;
    logic       cell_end;
    logic       c_rise;
    logic       last_bit;
    logic       more_bytes;
    logic       field_done;
    logic [3:0] field_next;

    assign in_bits    = (state == ST_OP) || (state == ST_ADDR) || (state == ST_DUMMY) ||
                        (state == ST_WRITE) || (state == ST_READ);
    assign cell_end   = in_bits && (cnt == CELL_LAST);
    assign c_rise     = in_bits && (cnt == C_RISE);
    assign last_bit   = (bit_cnt == 5'd0);
    assign more_bytes = ((state == ST_WRITE) || (state == ST_READ)) && (byte_cnt != 16'd1);
    assign field_done = cell_end && last_bit && !more_bytes;

    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign clock_active = in_bits;
    assign S_n          = (state == ST_IDLE) || (state == ST_DESEL);
    assign C            = in_bits && (cnt >= C_RISE);
    assign wr_req       = (state == ST_WRITE) && (cnt == 16'd0) && (bit_cnt == 5'd7);
    // The first bit of a write byte comes straight from wr_data; the rest of
    // the byte is held in the shift register loaded on that same cycle.
    assign D            = !in_bits ? 1'b0 : (wr_req ? wr_data[7] : shift[23]);

    // Which phase follows the one that just finished, skipping empty phases.
    always_comb begin
        field_next = ST_HOLD;
        case (state)
            ST_OP: begin
                if (addr_en_q)              field_next = ST_ADDR;
                else if (dummy_q != 4'd0)   field_next = ST_DUMMY;
                else if (wr_len_q != 8'd0)  field_next = ST_WRITE;
                else if (rd_len_q != 16'd0) field_next = ST_READ;
            end
            ST_ADDR: begin
                if (dummy_q != 4'd0)        field_next = ST_DUMMY;
                else if (wr_len_q != 8'd0)  field_next = ST_WRITE;
                else if (rd_len_q != 16'd0) field_next = ST_READ;
            end
            ST_DUMMY: begin
                if (wr_len_q != 8'd0)       field_next = ST_WRITE;
                else if (rd_len_q != 16'd0) field_next = ST_READ;
            end
            ST_WRITE: begin
                if (rd_len_q != 16'd0)      field_next = ST_READ;
            end
            default: field_next = ST_HOLD;
        endcase
    end

    // Control path: state, counters and read handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cnt      <= 16'd0;
            bit_cnt  <= 5'd0;
            byte_cnt <= 16'd0;
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state <= ST_SETUP;
                        cnt   <= 16'd0;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state   <= ST_OP;
                        cnt     <= 16'd0;
                        bit_cnt <= 5'd7;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_OP, ST_ADDR, ST_DUMMY, ST_WRITE, ST_READ: begin
                    if ((state == ST_READ) && c_rise && last_bit) begin
                        rd_valid <= 1'b1;
                        rd_data  <= {rx[6:0], Q};
                    end
                    if (cell_end) begin
                        cnt <= 16'd0;
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end else if (more_bytes) begin
                            bit_cnt  <= 5'd7;
                            byte_cnt <= byte_cnt - 16'd1;
                        end else begin
                            state <= field_next;
                            case (field_next)
                                ST_ADDR:  bit_cnt <= 5'd23;
                                ST_DUMMY: bit_cnt <= {1'b0, dummy_q} - 5'd1;
                                ST_WRITE: begin
                                    bit_cnt  <= 5'd7;
                                    byte_cnt <= {8'd0, wr_len_q};
                                end
                                ST_READ: begin
                                    bit_cnt  <= 5'd7;
                                    byte_cnt <= rd_len_q;
                                end
                                default: bit_cnt <= 5'd0;
                            endcase
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_DESEL;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DESEL: begin
                    if (cnt == DESEL_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data path: descriptor latch and shift registers (no reset needed).
    always_ff @(posedge CLK) begin
        if ((state == ST_IDLE) && cmd_valid) begin
            addr_en_q <= cmd_addr_en;
            addr_q    <= cmd_addr;
            dummy_q   <= cmd_dummy;
            wr_len_q  <= cmd_wr_len;
            rd_len_q  <= cmd_rd_len;
            shift     <= {cmd_op, 16'd0};
        end else if (wr_req) begin
            shift[23:16] <= wr_data;
        end else if (field_done) begin
            shift <= (field_next == ST_ADDR) ? addr_q : 24'd0;
        end else if (cell_end) begin
            shift <= {shift[22:0], 1'b0};
        end
        if ((state == ST_READ) && c_rise) begin
            rx <= {rx[6:0], Q};
        end
    end

endmodule

// File: tb/tb_spi_frame_driver.sv
// Testbench for spi_frame_driver: directed and randomized frames checked
// against a bit-level frame model built from the descriptor fields.
module tb_spi_frame_driver;

    localparam int DIV   = 2;
    localparam int CSS   = 2;
    localparam int CSH   = 2;
    localparam int DESEL = 4;
    localparam int CELL  = 2 * DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_op = 8'd0;
    logic [23:0] cmd_addr = 24'd0;
    logic        cmd_addr_en = 1'b0;
    logic [3:0]  cmd_dummy = 4'd0;
    logic [7:0]  cmd_wr_len = 8'd0;
    logic [15:0] cmd_rd_len = 16'd0;
    logic        wr_req;
    logic [7:0]  wr_data = 8'd0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic        clock_active;
    logic        S_n;
    logic        C;
    logic        D;
    logic        Q = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] wq[$];
    logic [7:0] rq[$];

    spi_frame_driver #(.DIV(DIV), .CSS(CSS), .CSH(CSH), .DESEL(DESEL)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_addr_en(cmd_addr_en),
        .cmd_dummy(cmd_dummy), .cmd_wr_len(cmd_wr_len), .cmd_rd_len(cmd_rd_len),
        .wr_req(wr_req), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .clock_active(clock_active),
        .S_n(S_n), .C(C), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Runs one frame starting just after a falling edge. wq/rq hold the write
    // bytes and the bytes the flash returns on Q.
    task automatic run_frame(input string tag, input logic [7:0] op, input logic ae,
                             input logic [23:0] addr, input logic [3:0] dm,
                             input logic [7:0] wl, input logic [15:0] rl, input bit hold);
        int nb, win_end, exp_ready, wstart, rstart, i, k, ph, nmin;
        int d_bad = 0, c_bad = 0, ca_bad = 0, ca_hi = 0, sn_bad = 0, sn_hi = 0;
        int bz_bad = 0, wr_cnt = 0, wr_bad = 0, rv_cnt = 0, rv_bad = 0, bs_bad = 0;
        bit ed[$];
        bit qb[$];
        bit got[$];
        logic prev_c, exp_wr, in_win;
        logic [7:0] t;

        wstart    = 8 + 24 * int'(ae) + int'(dm);
        rstart    = wstart + 8 * int'(wl);
        nb        = rstart + 8 * int'(rl);
        win_end   = CSS + CELL * nb;
        exp_ready = win_end + CSH + DESEL;

        for (int b = 7; b >= 0; b--) ed.push_back(op[b]);
        if (ae) for (int b = 23; b >= 0; b--) ed.push_back(addr[b]);
        for (int b = 0; b < int'(dm); b++) ed.push_back(1'b0);
        for (int j = 0; j < int'(wl); j++) begin
            t = wq[j];
            for (int b = 7; b >= 0; b--) ed.push_back(t[b]);
        end
        for (int b = 0; b < 8 * int'(rl); b++) ed.push_back(1'b0);
        for (int x = 0; x < nb; x++) begin
            if (x >= rstart) begin
                t = rq[(x - rstart) / 8];
                qb.push_back(t[7 - (x - rstart) % 8]);
            end else begin
                qb.push_back(1'($urandom));
            end
        end

        cmd_op = op; cmd_addr = addr; cmd_addr_en = ae; cmd_dummy = dm;
        cmd_wr_len = wl; cmd_rd_len = rl; cmd_valid = 1'b1;
        #1;
        check({tag, " ready_at_accept"}, cmd_ready, 1);
        @(posedge CLK);
        i = 0;
        prev_c = 1'b0;
        while (1) begin
            @(negedge CLK);
            if (i == 0 && !hold) begin
                cmd_valid = 1'b0;
                cmd_op = 8'($urandom); cmd_addr = 24'($urandom); cmd_addr_en = 1'($urandom);
                cmd_dummy = 4'($urandom); cmd_wr_len = 8'($urandom); cmd_rd_len = 16'($urandom);
            end
            Q = 1'($urandom);
            wr_data = 8'($urandom);
            in_win = (i >= CSS) && (i < win_end);
            exp_wr = 1'b0;
            if (in_win) begin
                k  = (i - CSS) / CELL;
                ph = (i - CSS) % CELL;
                Q  = qb[k];
                if (ph == 0 && k >= wstart && k < rstart && (k - wstart) % 8 == 0) begin
                    exp_wr  = 1'b1;
                    wr_data = wq[(k - wstart) / 8];
                end
            end
            #1;
            if (in_win) begin
                if (D !== ed[k]) d_bad++;
                if (C !== (ph >= DIV)) c_bad++;
            end else if (C !== 1'b0) c_bad++;
            if (clock_active !== in_win) ca_bad++;
            if (clock_active) ca_hi++;
            if (S_n !== (i >= win_end + CSH)) sn_bad++;
            if (S_n) sn_hi++;
            if (busy !== (i < exp_ready)) bz_bad++;
            if (wr_req !== exp_wr) wr_bad++;
            if (wr_req) wr_cnt++;
            if (C && !prev_c) got.push_back(D);
            prev_c = C;
            if (rd_valid) begin
                if (rv_cnt < rq.size()) begin
                    if (rd_data !== rq[rv_cnt]) rv_bad++;
                end else rv_bad++;
                rv_cnt++;
            end
            if (cmd_ready || i > exp_ready + 20) break;
            i++;
        end

        nmin = (got.size() < nb) ? got.size() : nb;
        for (int j = 0; j < nmin; j++) if (got[j] != ed[j]) bs_bad++;
        check({tag, " frame_len"}, i + 1, exp_ready + 1);
        check({tag, " bit_count"}, got.size(), nb);
        check({tag, " bit_stream_errs"}, bs_bad, 0);
        check({tag, " D_cycle_errs"}, d_bad, 0);
        check({tag, " C_errs"}, c_bad, 0);
        check({tag, " clock_active_errs"}, ca_bad, 0);
        check({tag, " clock_active_cycles"}, ca_hi, CELL * nb);
        check({tag, " S_n_errs"}, sn_bad, 0);
        check({tag, " S_n_high_cycles"}, sn_hi, DESEL + 1);
        check({tag, " busy_errs"}, bz_bad, 0);
        check({tag, " wr_req_count"}, wr_cnt, int'(wl));
        check({tag, " wr_req_timing_errs"}, wr_bad, 0);
        check({tag, " rd_valid_count"}, rv_cnt, int'(rl));
        check({tag, " rd_data_errs"}, rv_bad, 0);
        if (rl != 16'd0) check({tag, " rd_data_hold"}, rd_data, rq[rq.size() - 1]);
    endtask

    initial begin
        int rv_seen;
        repeat (3) @(negedge CLK);
        #1;
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst clock_active", clock_active, 0);
        check("rst S_n", S_n, 1);
        check("rst C", C, 0);
        check("rst D", D, 0);
        check("rst wr_req", wr_req, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Read ID
        wq = {}; rq = {8'hEF, 8'h40, 8'h14};
        run_frame("rdid", 8'h9F, 1'b0, 24'd0, 4'd0, 8'd0, 16'd3, 1'b0);
        @(negedge CLK);

        // Fast read with dummy bits
        wq = {}; rq = {8'h3C};
        run_frame("fread", 8'h0B, 1'b1, 24'h0A5A5A, 4'd8, 8'd0, 16'd1, 1'b0);
        @(negedge CLK);

        // Page program
        wq = {8'h55, 8'hAA}; rq = {};
        run_frame("pp", 8'h02, 1'b1, 24'h000100, 4'd0, 8'd2, 16'd0, 1'b0);
        @(negedge CLK);

        // Opcode only
        wq = {}; rq = {};
        run_frame("wren", 8'h06, 1'b0, 24'd0, 4'd0, 8'd0, 16'd0, 1'b0);
        @(negedge CLK);

        // Reset in the middle of the address phase
        cmd_op = 8'h03; cmd_addr = 24'h123456; cmd_addr_en = 1'b1; cmd_dummy = 4'd0;
        cmd_wr_len = 8'd0; cmd_rd_len = 16'd2; cmd_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        repeat (CSS + CELL * 13) @(negedge CLK);
        #1;
        check("midrst in_addr clock_active", clock_active, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst S_n", S_n, 1);
        check("midrst C", C, 0);
        check("midrst clock_active", clock_active, 0);
        check("midrst cmd_ready", cmd_ready, 1);
        check("midrst busy", busy, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        rv_seen = 0;
        repeat (4) begin
            @(negedge CLK);
            #1;
            if (rd_valid) rv_seen++;
        end
        check("midrst no_rd_valid", rv_seen, 0);
        @(negedge CLK);
        wq = {}; rq = {8'hA7, 8'h19};
        run_frame("after_rst", 8'h03, 1'b1, 24'h123456, 4'd0, 8'd0, 16'd2, 1'b0);
        @(negedge CLK);

        // Back-to-back descriptors held on cmd_valid
        wq = {}; rq = {8'h5E};
        run_frame("b2b_first", 8'h05, 1'b0, 24'd0, 4'd0, 8'd0, 16'd1, 1'b1);
        run_frame("b2b_second", 8'h05, 1'b0, 24'd0, 4'd0, 8'd0, 16'd1, 1'b0);
        @(negedge CLK);

        // Randomized descriptors
        for (int r = 0; r < 6; r++) begin
            logic [7:0]  op;
            logic        ae;
            logic [23:0] ad;
            logic [3:0]  dm;
            logic [7:0]  wl;
            logic [15:0] rl;
            op = 8'($urandom); ae = 1'($urandom); ad = 24'($urandom);
            dm = 4'($urandom_range(0, 15)); wl = 8'($urandom_range(0, 3));
            rl = 16'($urandom_range(0, 3));
            wq = {}; rq = {};
            for (int j = 0; j < int'(wl); j++) wq.push_back(8'($urandom));
            for (int j = 0; j < int'(rl); j++) rq.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", r), op, ae, ad, dm, wl, rl, 1'b0);
            @(negedge CLK);
        end

        // Read longer than 255 bytes
        wq = {}; rq = {};
        for (int j = 0; j < 300; j++) rq.push_back(8'($urandom));
        run_frame("long_read", 8'h03, 1'b1, 24'h0FFFFF, 4'd0, 8'd0, 16'd300, 1'b0);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_driver.md
# spi_frame_driver

Upstream stage of the FM25Q08A serial clock generator. Accepts one command descriptor at a time and drives a complete SPI mode-0 frame: chip select, serial clock, MOSI, and MISO capture. While the frame is active it holds `clock_active` high so the clock generator runs. Its serial clock `C` is derived from the system clock, so the whole frame is cycle-exact and reproducible in simulation.

## Interface
- `DIV`, 2: system cycles per serial-clock half period (≥1).
- `CSS`, 2: system cycles from `S_n` fall to the first `C` activity.
- `CSH`, 2: system cycles from the last `C` fall to `S_n` rise.
- `DESEL`, 4: minimum system cycles `S_n` stays high before the next frame.

Ports:
- `CLK` in 1: system clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: descriptor valid.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 8: opcode.
- `cmd_addr` in 24: address.
- `cmd_addr_en` in 1: send address phase.
- `cmd_dummy` in 4: dummy bit-cycles, 0–15.
- `cmd_wr_len` in 8: write bytes, 0–255.
- `cmd_rd_len` in 16: read bytes, 0–65535.
- `wr_req` out 1: one-cycle pulse; `wr_data` is sampled in that same cycle.
- `wr_data` in 8: write byte.
- `rd_valid` out 1: one-cycle pulse with `rd_data`.
- `rd_data` out 8: captured read byte.
- `busy` out 1: frame in progress (not IDLE).
- `clock_active` out 1: high from the first `C` low phase to the end of the last bit.
- `S_n` out 1: chip select, active low.
- `C` out 1: serial clock.
- `D` out 1: MOSI.
- `Q` in 1: MISO.

## Operation
- Reset values: `cmd_ready`=1, `busy`=0, `clock_active`=0, `S_n`=1, `C`=0, `D`=0, `wr_req`=0, `rd_valid`=0, `rd_data`=0. State is IDLE.
- States: IDLE → SETUP → OP → ADDR → DUMMY → WRITE → READ → HOLD → DESELECT → IDLE.
- ADDR is skipped if `cmd_addr_en`=0. DUMMY is skipped if `cmd_dummy`=0. WRITE is skipped if `cmd_wr_len`=0. READ is skipped if `cmd_rd_len`=0.
- Descriptor acceptance: when `cmd_valid && cmd_ready`, all `cmd_*` fields are latched. Later changes on `cmd_*` have no effect on the frame.
- Bit cell: 2·DIV system cycles. `D` updates on the first cycle of the cell, with `C`=0 for DIV cycles, then `C`=1 for DIV cycles. All fields are sent MSB first.
- `Q` is sampled on the system cycle in which `C` goes 0→1.
- Dummy bits drive `D`=0. Read bits drive `D`=0.
- WRITE: `wr_req` pulses on the first cycle of each byte's first bit cell. That byte's MSB appears on `D` on the same cycle, taken combinationally from `wr_data` and then held registered.
- READ: after the 8th sample of a byte, `rd_data` is loaded and `rd_valid` pulses for one cycle. `rd_data` holds its value until the next byte.
- Counters: the byte counter is 16 bits wide and the bit counter is 5 bits wide (covering 24 address bits). There is no wrap-around: an `rd_len` of 65535 runs to completion.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). The partial frame is discarded and no `rd_valid` is issued.

## Timing
- `cmd_ready` drops on the cycle after acceptance, and `S_n` falls on that same cycle (SETUP).
- SETUP lasts CSS cycles. `clock_active` rises on the first cycle of the first OP bit cell.
- The last bit cell ends with `C` returning to 0. `clock_active` falls on that same cycle, then HOLD lasts CSH cycles.
- `S_n` rises at the start of DESELECT. DESELECT lasts DESEL cycles, then `cmd_ready` reasserts.
- Total frame length from acceptance to `cmd_ready` reasserting: 1 + CSS + 2·DIV·N + CSH + DESEL cycles.
  - N = 8 + 24·addr_en + dummy + 8·wr_len + 8·rd_len.
- `cmd_valid` asserted during a frame is ignored (`cmd_ready` is 0). It is accepted at the first IDLE cycle if still asserted.
- A back-to-back descriptor present on the IDLE cycle is accepted on that cycle. IDLE lasts at least 1 cycle.

## Test plan
- Opcode 0x9F, addr_en=0, rd_len=3, `Q` driving 0xEF,0x40,0x14 → `D` carries 10011111, then 24 zeros. `rd_valid` pulses 3 times with 0xEF, 0x40, 0x14. N=32, so the frame is 1+2+128+2+4=137 cycles.
- Opcode 0x0B, addr 0x0A5A5A, dummy=8, rd_len=1, `Q`=0x3C → the address bits on `D` match 0x0A5A5A MSB-first. `Q` is ignored during the dummy bits and `rd_data`=0x3C.
- Opcode 0x02, addr 0x000100, wr_len=2, data 0x55,0xAA → exactly 2 `wr_req` pulses, each aligned to a byte start. The bit stream on `D` is correct, and `rd_valid` never asserts.
- Opcode 0x06 alone → 8 bit cells, then `S_n` rises. `clock_active` is high for exactly 8·2·DIV cycles.
- `RST_N` pulled low mid-ADDR → `S_n`=1, `C`=0 and `clock_active`=0 in the same cycle. After release, `cmd_ready`=1 and a new frame runs cleanly.
- Two descriptors held back-to-back on `cmd_valid` → the second is accepted only after DESEL. `S_n` stays high for ≥DESEL+1 cycles between the frames.
